// File: rtl/lane_input_scheduler_if.sv
// rtl/lane_input_scheduler_if.sv - lane event stream between scheduler and judge
interface lane_input_scheduler_if #(
    parameter int LW   = 2,
    parameter int TS_W = 16
);
    logic            evt_valid;
    logic            evt_ready;
    logic [LW-1:0]   evt_lane;
    logic            evt_press;
    logic [TS_W-1:0] evt_time;

    modport master (
        output evt_valid,
        output evt_lane,
        output evt_press,
        output evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_lane,
        input  evt_press,
        input  evt_time,
        output evt_ready
    );
endinterface

// File: rtl/lane_input_scheduler.sv
// rtl/lane_input_scheduler.sv - keyboard lane events to timestamped FWFT event queue
module lane_input_scheduler #(
    parameter int                     NUM_LANES  = 4,
    parameter logic [NUM_LANES*9-1:0] LANE_CODES = {9'h023, 9'h02B, 9'h03B, 9'h042},
    parameter int                     DEPTH      = 8,
    parameter int                     TS_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [511:0]           key_down,
    input  logic [8:0]             last_change,
    input  logic                   key_valid,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   stop,
    lane_input_scheduler_if.master evt,
    output logic [NUM_LANES-1:0]   lane_held,
    output logic                   busy,
    output logic                   overflow
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = LW + 1 + TS_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic [TS_W-1:0] ts;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            hit;
    logic [LW-1:0]   hit_lane;
    logic            hit_press;
    logic            push;
    logic            pop;
    logic            full;
    logic            do_push;
    logic [EW-1:0]   head;

    // A lane event is a change of held state; typematic repeats leave it unchanged.
    always_comb begin
        hit       = 1'b0;
        hit_lane  = '0;
        hit_press = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (key_valid && last_change == LANE_CODES[i*9 +: 9]) begin
                hit_lane  = LW'(i);
                hit_press = key_down[last_change];
                hit       = key_down[last_change] != lane_held[i];
            end
        end
    end

    assign full    = (count == FULL_CNT);
    assign pop     = evt.evt_valid && evt.evt_ready;
    assign push    = hit && (state == RUN);
    assign do_push = push && (!full || pop);

    assign head          = mem[rd_ptr];
    assign evt.evt_valid = (count != '0);
    assign evt.evt_lane  = evt.evt_valid ? head[EW-1 -: LW] : '0;
    assign evt.evt_press = evt.evt_valid ? head[TS_W]       : 1'b0;
    assign evt.evt_time  = evt.evt_valid ? head[TS_W-1:0]   : '0;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ts       <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= RUN;
                        ts       <= '0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (tick && ts != '1) begin
                        ts <= ts + 1'b1;
                    end
                    if (push && full && !pop) begin
                        overflow <= 1'b1;
                    end
                    if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_held <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_held[i] <= key_down[LANE_CODES[i*9 +: 9]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries between rd_ptr and wr_ptr are ever shown.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {hit_lane, hit_press, ts};
        end
    end
endmodule

// File: tb/tb_lane_input_scheduler.sv
// tb/tb_lane_input_scheduler.sv - self-checking bench for lane_input_scheduler
module tb_lane_input_scheduler;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] kd = '0;
    logic [8:0]   last_change = '0;
    logic         key_valid = 1'b0;
    logic         tick = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         ready = 1'b0;
    logic [3:0]   lane_held;
    logic         busy;
    logic         overflow;

    lane_input_scheduler_if #(.LW(2), .TS_W(16)) evt ();
    assign evt.evt_ready = ready;

    lane_input_scheduler dut (
        .clk(clk), .rst(rst), .key_down(kd), .last_change(last_change),
        .key_valid(key_valid), .tick(tick), .start(start), .stop(stop),
        .evt(evt), .lane_held(lane_held), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int lane; bit press; int ts; } ev_t;
    ev_t q[$];
    int  codes[4] = '{'h042, 'h03B, 'h02B, 'h023};
    int  mode = 0;
    int  mts = 0;
    bit  movf = 1'b0;
    bit [3:0] mheld = '0;
    int  n_checks = 0;
    int  n_fail = 0;

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = 0; mts = 0; movf = 1'b0; mheld = '0;
    endtask

    task automatic model_step();
        bit   pop;
        int   qn;
        int   ln;
        ev_t  e;
        bit   ev;
        if (rst) begin
            model_reset();
            return;
        end
        qn  = q.size();
        pop = (qn != 0) && ready;
        ln  = -1;
        ev  = 1'b0;
        for (int i = 0; i < 4; i++)
            if (key_valid && int'(last_change) == codes[i]) ln = i;
        if (ln >= 0) begin
            e.lane = ln; e.press = kd[codes[ln]]; e.ts = mts;
            ev = (kd[codes[ln]] != mheld[ln]);
        end
        if (pop) void'(q.pop_front());
        if (mode == 1 && ev) begin
            if (qn == 8 && !pop) movf = 1'b1;
            else q.push_back(e);
        end
        for (int i = 0; i < 4; i++) mheld[i] = kd[codes[i]];
        case (mode)
            0: if (start && !stop) begin mode = 1; mts = 0; movf = 1'b0; end
            1: begin
                if (tick && mts < 65535) mts++;
                if (stop) mode = 2;
            end
            default: if (qn == 0) mode = 0;
        endcase
    endtask

    task automatic compare();
        check("evt_valid", evt.evt_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("evt_lane", evt.evt_lane, q[0].lane);
            check("evt_press", evt.evt_press, q[0].press);
            check("evt_time", evt.evt_time, q[0].ts);
        end
        check("lane_held", lane_held, mheld);
        check("busy", busy, mode != 0);
        check("overflow", overflow, movf);
    endtask

    always @(posedge clk) begin
        #3;
        compare();
    end

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc(int n);
        repeat (n) step();
    endtask

    task automatic pulse_key(int code, bit down);
        kd[code] = down;
        last_change = 9'(code);
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        check("rst_valid", evt.evt_valid, 0);
        check("rst_lane", evt.evt_lane, 0);
        check("rst_press", evt.evt_press, 0);
        check("rst_time", evt.evt_time, 0);
        check("rst_held", lane_held, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);

        // press F at ts=5
        do_start();
        tick = 1'b1; cyc(5); tick = 1'b0;
        pulse_key('h02B, 1'b1);
        check("t1_valid", evt.evt_valid, 1);
        check("t1_lane", evt.evt_lane, 2);
        check("t1_press", evt.evt_press, 1);
        check("t1_time", evt.evt_time, 5);
        ready = 1'b1; step(); ready = 1'b0;
        check("t1_popped", evt.evt_valid, 0);

        // J held with repeats then released
        for (int k = 0; k < 3; k++) pulse_key('h03B, 1'b1);
        pulse_key('h03B, 1'b0);
        check("t2_lane_a", evt.evt_lane, 1);
        check("t2_press_a", evt.evt_press, 1);
        ready = 1'b1; step();
        check("t2_lane_b", evt.evt_lane, 1);
        check("t2_press_b", evt.evt_press, 0);
        step(); ready = 1'b0;
        check("t2_empty", evt.evt_valid, 0);

        // 9 events into an 8-deep queue
        for (int k = 0; k < 9; k++) pulse_key('h042, (k % 2) == 0);
        check("t3_ovf", overflow, 1);
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t3_valid", evt.evt_valid, 1);
            check("t3_lane", evt.evt_lane, 0);
            check("t3_press", evt.evt_press, (k % 2) == 0);
            step();
        end
        check("t3_empty", evt.evt_valid, 0);
        ready = 1'b0;
        do_stop(); cyc(2);
        check("t3_idle", busy, 0);
        check("t3_ovf_sticky", overflow, 1);
        do_start();
        check("t3_ovf_clr", overflow, 0);

        // full queue with simultaneous pop and push
        for (int k = 0; k < 8; k++) pulse_key('h023, (k % 2) == 0);
        ready = 1'b1;
        pulse_key('h042, 1'b0);
        check("t4_ovf", overflow, 0);
        check("t4_head_lane", evt.evt_lane, 3);
        check("t4_head_press", evt.evt_press, 0);
        n = 0;
        while (evt.evt_valid && n < 20) begin
            step(); n++;
        end
        check("t4_count", n, 8);
        ready = 1'b0;

        // drain with 3 queued, lane key during drain ignored
        pulse_key('h03B, 1'b1);
        pulse_key('h03B, 1'b0);
        pulse_key('h03B, 1'b1);
        do_stop();
        check("t5_busy_stop", busy, 1);
        pulse_key('h02B, 1'b1);
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t5_busy", busy, 1);
            check("t5_valid", evt.evt_valid, 1);
            step();
        end
        check("t5_empty", evt.evt_valid, 0);
        check("t5_busy_last", busy, 1);
        ready = 1'b0; step();
        check("t5_idle", busy, 0);

        // reset while 4 events queued
        do_start();
        pulse_key('h03B, 1'b0);
        pulse_key('h02B, 1'b0);
        pulse_key('h023, 1'b1);
        pulse_key('h042, 1'b1);
        check("t6_held_pre", lane_held, 4'b1001);
        check("t6_valid_pre", evt.evt_valid, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_valid", evt.evt_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_held", lane_held, 0);
        step();
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int code;
            ready = ((i / 400) % 2 == 1) ? ($urandom % 8 == 0) : ($urandom % 3 != 0);
            tick  = ($urandom % 4) == 0;
            start = ($urandom % 50) == 0;
            stop  = ($urandom % 80) == 0;
            if ($urandom % 5 < 2) begin
                if ($urandom % 4 != 0) code = codes[$urandom % 4];
                else code = int'($urandom_range(0, 511));
                if ($urandom % 3 != 0) kd[code] = ~kd[code];
                last_change = 9'(code);
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            step();
        end
        key_valid = 1'b0; start = 1'b0; tick = 1'b0;
        stop = 1'b1; ready = 1'b1;
        step();
        stop = 1'b0;
        cyc(30);
        check("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
